// File: rtl/bicubic_pix_pack.sv
// bicubic_pix_pack: output stage behind the bicubic multiply-add.
// Re-aligns the un-tagged arithmetic result with a valid/SOF tag delayed by
// PIPE_LAT cycles, clamps it to 8-bit unsigned, buffers it in a small
// first-word-fall-through FIFO and presents it as a ready/valid stream with
// start-of-frame / end-of-line flags.
// Optional build macro: CLAMP_STAT_EN adds saturating clip counters
// (clip_lo_cnt, clip_hi_cnt), cleared on every transferred start of frame.
module bicubic_pix_pack #(
    parameter int PIPE_LAT   = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int LINE_W     = 1920,
    parameter int FRAME_H    = 1080
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pre_valid,
    input  logic        pre_sof,
    input  logic [16:0] din,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eol,
    output logic        ovf_err,
    input  logic        err_clr
`ifdef CLAMP_STAT_EN
    ,
    output logic [15:0] clip_lo_cnt,
    output logic [15:0] clip_hi_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int RW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;

    localparam logic [CW-1:0] COL_LAST      = CW'(LINE_W - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(FRAME_H - 1);
    localparam logic [RW-1:0] ROW_AFTER_TAG = RW'(1 % FRAME_H);
    localparam logic [AW:0]   CNT_FULL      = (AW + 1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Tag delay line: tap PIPE_LAT-1 lines up with the matching din.
    // ------------------------------------------------------------------
    logic [PIPE_LAT-1:0] vld_dl;
    logic [PIPE_LAT-1:0] sof_dl;
    logic [PIPE_LAT-1:0] vld_nxt;
    logic [PIPE_LAT-1:0] sof_nxt;
    logic                al_vld;
    logic                al_sof;

    generate
        if (PIPE_LAT > 1) begin : g_shift
            assign vld_nxt = {vld_dl[PIPE_LAT-2:0], pre_valid};
            assign sof_nxt = {sof_dl[PIPE_LAT-2:0], pre_valid & pre_sof};
        end else begin : g_single
            assign vld_nxt = pre_valid;
            assign sof_nxt = pre_valid & pre_sof;
        end
    endgenerate

    assign al_vld = vld_dl[PIPE_LAT-1];
    assign al_sof = sof_dl[PIPE_LAT-1];

    // Shift the valid/sof tags alongside the arithmetic pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_dl <= '0;
            sof_dl <= '0;
        end else begin
            vld_dl <= vld_nxt;
            sof_dl <= sof_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Clamp stage
    // ------------------------------------------------------------------
    logic [7:0] clamp_val;
    logic       clip_lo;
    logic       clip_hi;
    logic [7:0] clamp_data;
    logic       clamp_vld;
    logic       clamp_sof;

    // Saturate the signed 17-bit result into 0..255.
    always_comb begin
        clamp_val = din[7:0];
        clip_lo   = 1'b0;
        clip_hi   = 1'b0;
        if (din[16]) begin
            clamp_val = '0;
            clip_lo   = 1'b1;
        end else if (|din[15:8]) begin
            clamp_val = '1;
            clip_hi   = 1'b1;
        end
    end

    // Register the clamped pixel together with its valid and sof tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clamp_data <= '0;
            clamp_vld  <= 1'b0;
            clamp_sof  <= 1'b0;
        end else begin
            clamp_vld <= al_vld;
            if (al_vld) begin
                clamp_data <= clamp_val;
                clamp_sof  <= al_sof;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          fifo_full;
    logic          rd_en;
    logic          wr_en;
    logic          ovf_hit;
    logic          head_sof;

    assign fifo_full = (count == CNT_FULL);
    assign out_valid = (count != '0);
    assign rd_en     = out_valid & out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign wr_en     = clamp_vld & (~fifo_full | rd_en);
    assign ovf_hit   = clamp_vld & fifo_full & ~rd_en;

    // Storage holds no reset; emptiness is tracked by count and the
    // outputs are gated so nothing stale is visible while empty.
    assign out_data  = out_valid ? mem[rd_ptr][7:0] : '0;
    assign head_sof  = out_valid & mem[rd_ptr][8];

    // Write the {sof, pixel} word into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {clamp_sof, clamp_data};
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo FIFO_DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_err <= 1'b0;
        end else if (ovf_hit) begin
            ovf_err <= 1'b1;
        end else if (err_clr) begin
            ovf_err <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output position counters
    // ------------------------------------------------------------------
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    assign out_sof = head_sof | ((col == '0) && (row == '0));
    assign out_eol = (col == COL_LAST);

    // Advance col/row on each accepted transfer; a tagged head word
    // re-synchronises the position to just after the frame origin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (rd_en) begin
            if (head_sof) begin
                if (LINE_W == 1) begin
                    col <= '0;
                    row <= ROW_AFTER_TAG;
                end else begin
                    col <= CW'(1);
                    row <= '0;
                end
            end else if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

`ifdef CLAMP_STAT_EN
    // ------------------------------------------------------------------
    // Clip statistics
    // ------------------------------------------------------------------
    logic        sof_xfer;
    logic [15:0] lo_base;
    logic [15:0] hi_base;
    logic        lo_inc;
    logic        hi_inc;

    assign sof_xfer = rd_en & out_sof;

    // A transferred start of frame zeroes the counters before any new
    // clip in the same cycle is added; both saturate at 65535.
    always_comb begin
        lo_base = sof_xfer ? '0 : clip_lo_cnt;
        hi_base = sof_xfer ? '0 : clip_hi_cnt;
        lo_inc  = al_vld & clip_lo & ~(&lo_base);
        hi_inc  = al_vld & clip_hi & ~(&hi_base);
    end

    // Clip counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip_lo_cnt <= '0;
            clip_hi_cnt <= '0;
        end else begin
            clip_lo_cnt <= lo_base + {15'd0, lo_inc};
            clip_hi_cnt <= hi_base + {15'd0, hi_inc};
        end
    end
`endif

endmodule
